// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control logic.
//   NOP          : instruction word that a cleared pipeline register holds
//   state_e      : hazard controller states (ST_INIT, ST_RUN, ST_MEM_WAIT)
//   FWD_*        : EX-stage operand source select encodings
package pipeline_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage

// File: rtl/forward_sel.sv
// Forwarding source select for one EX-stage operand.
// Ports:
//   i_rs               source register read by the instruction in EX
//   i_ex_mem_rd/_we    destination and write enable of the instruction in MEM
//   i_mem_wb_rd/_we    destination and write enable of the instruction in WB
//   o_sel              FWD_RF / FWD_EXMEM / FWD_MEMWB
// The youngest producer (EX/MEM) wins; x0 is never forwarded so NOPs in flight
// cannot cause false matches.
module forward_sel
  import pipeline_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_ex_mem_rd,
  input  logic       i_ex_mem_we,
  input  logic [4:0] i_mem_wb_rd,
  input  logic       i_mem_wb_we,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_ex_mem_we && (i_ex_mem_rd != 5'd0) && (i_ex_mem_rd == i_rs)) begin
      o_sel = FWD_EXMEM;
    end else if (i_mem_wb_we && (i_mem_wb_rd != 5'd0) && (i_mem_wb_rd == i_rs)) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for a five-stage pipeline.
// Produces per-stage stall (hold) and clear (load NOP) strobes plus EX operand
// forwarding selects. Handles a post-reset flush, load-use bubbles, taken-branch
// flushes and multi-cycle data-memory waits with a sticky timeout flag.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_*                        sources of the instruction in ID
//   id_ex_*                     sources/destination/load flag of the instruction in EX
//   ex_branch_taken             EX resolved a taken branch or jump
//   ex_mem_*                    MEM-stage destination, write enable, memory access flag
//   mem_ready                   data memory completes its access this cycle
//   mem_wb_*                    WB-stage destination and write enable
//   *_stall, *_clear            pipeline register strobes
//   fwd_a, fwd_b                EX operand source selects
//   mem_fault                   sticky memory-timeout flag
// Optional feature (macro HAZARD_PERF_EN): stall_cycles / flush_events counters.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned INIT_FLUSH_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT       = 64
`ifdef HAZARD_PERF_EN
  ,
  parameter int unsigned CNT_W             = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_is_load,
  input  logic             ex_branch_taken,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_reg_write,
  input  logic             ex_mem_is_mem,
  input  logic             mem_ready,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_reg_write,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_clear,
  output logic             id_ex_clear,
  output logic             ex_mem_clear,
  output logic             mem_wb_clear,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_fault
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  localparam int unsigned InitW = (INIT_FLUSH_CYCLES > 1) ? $clog2(INIT_FLUSH_CYCLES) : 1;
  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [InitW-1:0] InitLast = InitW'(INIT_FLUSH_CYCLES - 1);
  localparam logic [WaitW-1:0] WaitMax  = WaitW'(MEM_TIMEOUT);

  state_e           r_state, w_state_d;
  logic [InitW-1:0] r_init_cnt, w_init_cnt_d;
  logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_d;
  logic             r_mem_fault, w_mem_fault_d;

  logic w_mem_wait;
  logic w_load_use;

  assign w_mem_wait = ex_mem_is_mem && !mem_ready;
  assign w_load_use = id_ex_is_load && (id_ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == id_ex_rd)));

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_clear  = 1'b0;
    id_ex_clear  = 1'b0;
    ex_mem_clear = 1'b0;
    mem_wb_clear = 1'b0;
    w_state_d    = r_state;
    w_init_cnt_d = r_init_cnt;
    w_wait_cnt_d = r_wait_cnt;

    if (rst) begin
      if_id_clear  = 1'b1;
      id_ex_clear  = 1'b1;
      ex_mem_clear = 1'b1;
      mem_wb_clear = 1'b1;
    end else begin
      unique case (r_state)
        ST_INIT: begin
          if_id_clear  = 1'b1;
          id_ex_clear  = 1'b1;
          ex_mem_clear = 1'b1;
          mem_wb_clear = 1'b1;
          if (r_init_cnt == InitLast) begin
            w_state_d    = ST_RUN;
            w_init_cnt_d = '0;
          end else begin
            w_init_cnt_d = r_init_cnt + InitW'(1);
          end
        end

        ST_RUN: begin
          if (w_mem_wait) begin
            // EX is frozen, so a branch or load-use seen now is re-evaluated after release.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_clear = 1'b1;
            w_state_d    = ST_MEM_WAIT;
            w_wait_cnt_d = WaitW'(1);
          end else if (ex_branch_taken) begin
            // The load-use dependent is flushed too, so no bubble is needed.
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
          end else if (w_load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_clear = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          if (mem_ready) begin
            w_state_d    = ST_RUN;
            w_wait_cnt_d = '0;
          end else begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_clear = 1'b1;
            if (r_wait_cnt < WaitMax) begin
              w_wait_cnt_d = r_wait_cnt + WaitW'(1);
            end
          end
        end

        default: begin
          // Unreachable encoding: flush and restart the init sequence.
          if_id_clear  = 1'b1;
          id_ex_clear  = 1'b1;
          ex_mem_clear = 1'b1;
          mem_wb_clear = 1'b1;
          w_state_d    = ST_INIT;
          w_init_cnt_d = '0;
          w_wait_cnt_d = '0;
        end
      endcase
    end
  end

  // Fault latches on the edge where the wait count arrives at the timeout.
  assign w_mem_fault_d = r_mem_fault || (w_wait_cnt_d == WaitMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_mem_fault <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_init_cnt  <= w_init_cnt_d;
      r_wait_cnt  <= w_wait_cnt_d;
      r_mem_fault <= w_mem_fault_d;
    end
  end

  assign mem_fault = r_mem_fault;

  forward_sel u_fwd_a (
    .i_rs        (id_ex_rs1),
    .i_ex_mem_rd (ex_mem_rd),
    .i_ex_mem_we (ex_mem_reg_write),
    .i_mem_wb_rd (mem_wb_rd),
    .i_mem_wb_we (mem_wb_reg_write),
    .o_sel       (fwd_a)
  );

  forward_sel u_fwd_b (
    .i_rs        (id_ex_rs2),
    .i_ex_mem_rd (ex_mem_rd),
    .i_ex_mem_we (ex_mem_reg_write),
    .i_mem_wb_rd (mem_wb_rd),
    .i_mem_wb_we (mem_wb_reg_write),
    .o_sel       (fwd_b)
  );

`ifdef HAZARD_PERF_EN
  logic             w_flush;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  assign w_flush = !rst && (r_state == ST_RUN) && !w_mem_wait && ex_branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (pc_stall) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush) begin
        r_flush_events <= r_flush_events + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: fixed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_hazard_controller;
  import pipeline_pkg::*;

  localparam int unsigned InitCycles = 4;
  localparam int unsigned Timeout    = 64;

  // Strobe order: {pc, if_id, id_ex, ex_mem stalls, if_id, id_ex, ex_mem, mem_wb clears}
  localparam logic [7:0] SNone     = 8'b0000_0000;
  localparam logic [7:0] SFlush    = 8'b0000_1111;
  localparam logic [7:0] SMemStall = 8'b1111_0001;
  localparam logic [7:0] SBranch   = 8'b0000_1100;
  localparam logic [7:0] SLoadUse  = 8'b1100_0100;

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_ex_rs1;
    logic [4:0] id_ex_rs2;
    logic [4:0] id_ex_rd;
    logic       id_ex_is_load;
    logic       ex_branch_taken;
    logic [4:0] ex_mem_rd;
    logic       ex_mem_reg_write;
    logic       ex_mem_is_mem;
    logic       mem_ready;
    logic [4:0] mem_wb_rd;
    logic       mem_wb_reg_write;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [7:0] strb;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  cur;

  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_fault;
  logic [7:0] dut_strb;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  assign dut_strb = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                     if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear};

  always #5 clk = ~clk;

  hazard_controller #(
    .INIT_FLUSH_CYCLES (InitCycles),
    .MEM_TIMEOUT       (Timeout)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1           (cur.id_rs1),
    .id_rs2           (cur.id_rs2),
    .id_uses_rs1      (cur.id_uses_rs1),
    .id_uses_rs2      (cur.id_uses_rs2),
    .id_ex_rs1        (cur.id_ex_rs1),
    .id_ex_rs2        (cur.id_ex_rs2),
    .id_ex_rd         (cur.id_ex_rd),
    .id_ex_is_load    (cur.id_ex_is_load),
    .ex_branch_taken  (cur.ex_branch_taken),
    .ex_mem_rd        (cur.ex_mem_rd),
    .ex_mem_reg_write (cur.ex_mem_reg_write),
    .ex_mem_is_mem    (cur.ex_mem_is_mem),
    .mem_ready        (cur.mem_ready),
    .mem_wb_rd        (cur.mem_wb_rd),
    .mem_wb_reg_write (cur.mem_wb_reg_write),
    .pc_stall         (pc_stall),
    .if_id_stall      (if_id_stall),
    .id_ex_stall      (id_ex_stall),
    .ex_mem_stall     (ex_mem_stall),
    .if_id_clear      (if_id_clear),
    .id_ex_clear      (id_ex_clear),
    .ex_mem_clear     (ex_mem_clear),
    .mem_wb_clear     (mem_wb_clear),
    .fwd_a            (fwd_a),
    .fwd_b            (fwd_b),
    .mem_fault        (mem_fault)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: INIT cycles still to go, whether a memory access is
  // outstanding, how many wait cycles it has taken, and the sticky fault.
  int          m_init_left = 0, n_init_left;
  bit          m_waiting = 0, n_waiting;
  int          m_waited = 0, n_waited;
  bit          m_fault = 0, n_fault;
  bit          m_primed = 0;
  bit          n_stall, n_flush;
  int unsigned m_stall_cnt = 0, m_flush_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (cur.ex_mem_reg_write && cur.ex_mem_rd != 0 && cur.ex_mem_rd == rs) return 2'd1;
    if (cur.mem_wb_reg_write && cur.mem_wb_rd != 0 && cur.mem_wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_eval(output logic [7:0] s);
    bit lu;
    lu = cur.id_ex_is_load && cur.id_ex_rd != 0 &&
         ((cur.id_uses_rs1 && cur.id_rs1 == cur.id_ex_rd) ||
          (cur.id_uses_rs2 && cur.id_rs2 == cur.id_ex_rd));
    n_init_left = m_init_left;
    n_waiting   = m_waiting;
    n_waited    = m_waited;
    n_fault     = m_fault;
    n_flush     = 1'b0;
    if (rst) begin
      s = SFlush;
      n_init_left = InitCycles;
      n_waiting = 0;
      n_waited = 0;
      n_fault = 0;
    end else if (m_init_left > 0) begin
      s = SFlush;
      n_init_left = m_init_left - 1;
    end else if (m_waiting) begin
      if (cur.mem_ready) begin
        s = SNone;
        n_waiting = 0;
        n_waited = 0;
      end else begin
        s = SMemStall;
        n_waited = (m_waited < Timeout) ? m_waited + 1 : Timeout;
      end
    end else if (cur.ex_mem_is_mem && !cur.mem_ready) begin
      s = SMemStall;
      n_waiting = 1;
      n_waited = 1;
    end else if (cur.ex_branch_taken) begin
      s = SBranch;
      n_flush = 1'b1;
    end else if (lu) begin
      s = SLoadUse;
    end else begin
      s = SNone;
    end
    if (!rst && n_waited >= Timeout) n_fault = 1;
    n_stall = s[7];
  endtask

  task automatic model_commit();
    if (rst) begin
      m_primed = 1;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (n_stall) m_stall_cnt++;
      if (n_flush) m_flush_cnt++;
    end
    m_init_left = n_init_left;
    m_waiting   = n_waiting;
    m_waited    = n_waited;
    m_fault     = n_fault;
  endtask

  // One clock: compare at the falling edge, advance the model after the rising edge.
  task automatic step(input string name, input bit c_strb_en, input logic [7:0] c_strb,
                      input bit c_fwd_en, input logic [1:0] c_fa, input logic [1:0] c_fb);
    logic [7:0] s;
    logic [1:0] efa, efb;
    @(negedge clk);
    model_eval(s);
    efa = fwd_ref(cur.id_ex_rs1);
    efb = fwd_ref(cur.id_ex_rs2);
    if (c_strb_en) s = c_strb;
    if (c_fwd_en) begin
      efa = c_fa;
      efb = c_fb;
    end
    chk({name, "/strobes"}, int'(dut_strb), int'(s));
    if (m_primed) chk({name, "/mem_fault"}, int'(mem_fault), int'(m_fault));
    if (s[3:0] == 4'b0000) begin
      chk({name, "/fwd_a"}, int'(fwd_a), int'(efa));
      chk({name, "/fwd_b"}, int'(fwd_b), int'(efb));
    end
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic reset_seq(input string name, input int n_rst);
    rst = 1'b1;
    for (int i = 0; i < n_rst; i++) step({name, "_rst"}, 1, SFlush, 0, 2'd0, 2'd0);
    rst = 1'b0;
    chk({name, "_fault_cleared"}, int'(mem_fault), 0);
    for (int i = 0; i < int'(InitCycles); i++) step({name, "_init"}, 1, SFlush, 0, 2'd0, 2'd0);
  endtask

  vec_t tbl[$];

  initial begin
    in_t v;
    rst = 1'b1;
    cur = '0;

    // Reset: two reset cycles, exactly four INIT cycles, then quiet.
    reset_seq("reset", 2);
    step("post_init", 1, SNone, 1, 2'd0, 2'd0);

    // Single-cycle vectors applied in RUN.
    v = '0;
    tbl.push_back({v, SNone, 2'd0, 2'd0});
    v = '0; v.id_ex_is_load = 1; v.id_ex_rd = 5; v.id_rs2 = 5; v.id_uses_rs2 = 1;
    tbl.push_back({v, SLoadUse, 2'd0, 2'd0});
    v.id_ex_rd = 0; v.id_rs2 = 0;
    tbl.push_back({v, SNone, 2'd0, 2'd0});
    v = '0; v.id_ex_is_load = 1; v.id_ex_rd = 5; v.id_rs1 = 5; v.id_uses_rs1 = 0;
    tbl.push_back({v, SNone, 2'd0, 2'd0});
    v.id_uses_rs1 = 1;
    tbl.push_back({v, SLoadUse, 2'd0, 2'd0});
    v.ex_branch_taken = 1;
    tbl.push_back({v, SBranch, 2'd0, 2'd0});
    v = '0; v.ex_mem_rd = 7; v.ex_mem_reg_write = 1; v.mem_wb_rd = 7; v.mem_wb_reg_write = 1;
    v.id_ex_rs1 = 7; v.id_ex_rs2 = 3;
    tbl.push_back({v, SNone, 2'd1, 2'd0});
    v.ex_mem_reg_write = 0;
    tbl.push_back({v, SNone, 2'd2, 2'd0});
    v = '0; v.ex_mem_reg_write = 1; v.mem_wb_reg_write = 1;
    tbl.push_back({v, SNone, 2'd0, 2'd0});
    v = '0; v.ex_mem_rd = 9; v.mem_wb_rd = 9; v.mem_wb_reg_write = 1; v.id_ex_rs1 = 4;
    v.id_ex_rs2 = 9;
    tbl.push_back({v, SNone, 2'd0, 2'd2});
    v.ex_mem_reg_write = 1; v.id_ex_rs1 = 9;
    tbl.push_back({v, SNone, 2'd1, 2'd1});
    v = '0; v.ex_mem_is_mem = 1; v.mem_ready = 1;
    tbl.push_back({v, SNone, 2'd0, 2'd0});
    rst = 1'b0;
    foreach (tbl[i]) begin
      cur = tbl[i].in;
      step($sformatf("vec%0d", i), 1, tbl[i].strb, 1, tbl[i].fa, tbl[i].fb);
    end

    // Load-use gives one bubble; next cycle the load has moved on.
    cur = '0; cur.id_ex_is_load = 1; cur.id_ex_rd = 5; cur.id_rs2 = 5; cur.id_uses_rs2 = 1;
    step("lu_bubble", 1, SLoadUse, 0, 2'd0, 2'd0);
    cur.id_ex_is_load = 0; cur.id_ex_rd = 0;
    step("lu_after", 1, SNone, 0, 2'd0, 2'd0);

    // Memory wait of three cycles with a branch pending; branch acts after release.
    cur = '0; cur.ex_mem_is_mem = 1; cur.ex_branch_taken = 1;
    cur.id_ex_is_load = 1; cur.id_ex_rd = 6; cur.id_rs1 = 6; cur.id_uses_rs1 = 1;
    for (int i = 0; i < 3; i++) step("memwait", 1, SMemStall, 0, 2'd0, 2'd0);
    cur.mem_ready = 1;
    step("mem_release", 1, SNone, 0, 2'd0, 2'd0);
    cur.ex_mem_is_mem = 0;
    step("branch_after_wait", 1, SBranch, 0, 2'd0, 2'd0);
    cur = '0;
    step("quiet", 1, SNone, 0, 2'd0, 2'd0);

    // Timeout: fault rises once 64 wait cycles have elapsed and is sticky.
    cur = '0; cur.ex_mem_is_mem = 1; cur.mem_ready = 0;
    for (int k = 1; k <= 70; k++) begin
      step("timeout_wait", 1, SMemStall, 0, 2'd0, 2'd0);
      if (k >= 62 && k <= 66) chk($sformatf("fault_after_wait%0d", k), int'(mem_fault),
                                 (k >= int'(Timeout)) ? 1 : 0);
    end
    cur.mem_ready = 1;
    step("timeout_release", 1, SNone, 0, 2'd0, 2'd0);
    cur.ex_mem_is_mem = 0;
    for (int i = 0; i < 3; i++) step("fault_sticky", 1, SNone, 0, 2'd0, 2'd0);
    chk("fault_sticky_level", int'(mem_fault), 1);
    reset_seq("fault_reset", 1);

    // Reset asserted in the middle of a memory wait.
    cur = '0; cur.ex_mem_is_mem = 1;
    step("wait_then_rst", 1, SMemStall, 0, 2'd0, 2'd0);
    step("wait_then_rst", 1, SMemStall, 0, 2'd0, 2'd0);
    cur = '0;
    reset_seq("rst_in_wait", 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      cur.id_rs1           = 5'($urandom_range(0, 7));
      cur.id_rs2           = 5'($urandom_range(0, 7));
      cur.id_uses_rs1      = 1'($urandom_range(0, 1));
      cur.id_uses_rs2      = 1'($urandom_range(0, 1));
      cur.id_ex_rs1        = 5'($urandom_range(0, 7));
      cur.id_ex_rs2        = 5'($urandom_range(0, 7));
      cur.id_ex_rd         = 5'($urandom_range(0, 7));
      cur.id_ex_is_load    = 1'($urandom_range(0, 1));
      cur.ex_branch_taken  = ($urandom_range(0, 5) == 0);
      cur.ex_mem_rd        = 5'($urandom_range(0, 7));
      cur.ex_mem_reg_write = 1'($urandom_range(0, 1));
      cur.ex_mem_is_mem    = ($urandom_range(0, 2) == 0);
      cur.mem_ready        = ($urandom_range(0, 3) != 0);
      cur.mem_wb_rd        = 5'($urandom_range(0, 7));
      cur.mem_wb_reg_write = 1'($urandom_range(0, 1));
      step("rand", 0, SNone, 0, 2'd0, 2'd0);
    end

`ifdef HAZARD_PERF_EN
    chk("stall_cycles", int'(stall_cycles), int'(m_stall_cnt));
    chk("flush_events", int'(flush_events), int'(m_flush_cnt));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
